fifo2wb_master: RTL and testbench
=================================

Name: fifo2wb_master

Overview:
- Wishbone bus master that executes host register commands.
- Pops command words from the host-to-CPU command FIFO (cpuin side) and runs single-word Wishbone reads and writes.
- Pushes read data and one status word per command into the CPU-to-host FIFO (cpuout side).
- It is the initiator counterpart to the Wishbone slave bridge wb2fifo: the host drives peripherals over the FT600 link without ECPU firmware involvement.

Parameters:
- FT_DATA_WIDTH, 32, width of FIFO words and Wishbone data/address.
- TIMEOUT_CYCLES, 255, cycles a bus access may wait for ack/err before abort; range 1..65535.

Ports:
- clk  input  1  system clock; both FIFO ports and Wishbone run on it.
- reset_n  input  1  asynchronous, active-low reset.
- fifoin_data_i  input  32  command FIFO Q; valid the cycle after fifoin_rd_o (non-show-ahead).
- fifoin_empty_i  input  1  command FIFO empty.
- fifoin_rd_o  output  1  command FIFO read enable, one-cycle pulse per word.
- fifoout_data_o  output  32  response word.
- fifoout_wr_o  output  1  response FIFO write enable.
- fifoout_full_i  input  1  response FIFO full.
- wb_adr_o  output  32  byte address.
- wb_dat_o  output  32  write data.
- wb_dat_i  input  32  read data.
- wb_we_o  output  1  write enable.
- wb_cyc_o  output  1  cycle.
- wb_stb_o  output  1  strobe.
- wb_sel_o  output  4  byte select; constant 4'hF.
- wb_cti_o  output  3  constant 3'b000 (classic).
- wb_bte_o  output  2  constant 2'b00.
- wb_ack_i  input  1  slave ack.
- wb_err_i  input  1  slave error.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0 except the constants wb_sel_o=4'hF, wb_cti_o=0, wb_bte_o=0. State goes to IDLE and all counters clear. Reset mid-command abandons the command and drops cyc/stb immediately; no status word is pushed.
- Command frame:
  - Header word: [31:28] op (4'h1 WRITE, 4'h2 READ), [27:20] CNT, where N = CNT+1 words (1..256), other bits ignored.
  - Then an address word.
  - WRITE then carries N data words; READ carries none.
  - Word i accesses addr + 4*i; address wraps mod 2^32.
- Status word: {4'hA, op[3:0], CNT[7:0], 14'b0, st[1:0]}.
  - st: 00 OK, 01 bus error, 10 timeout, 11 bad opcode.
- FIFO pops: fifoin_rd_o is asserted only when fifoin_empty_i=0; the word is captured the next cycle.
- FIFO pushes: fifoout_wr_o is asserted only when fifoout_full_i=0; fifoout_data_o is stable while waiting.
- States:
  - IDLE: if !empty, pop -> HDR.
  - HDR: latch op/CNT, load remaining=N. Bad op -> RESP (st=11; only the header is consumed). Otherwise wait !empty, pop -> ADDR.
  - ADDR: latch address. WRITE -> WFETCH; READ -> BUS.
  - WFETCH: wait !empty, pop -> WDATA.
  - WDATA: latch data into wb_dat_o -> BUS.
  - BUS: cyc=stb=1, we=(op==WRITE); the timeout counter runs.
    - ack: drop cyc/stb the same clock edge. READ -> RPUSH with data=wb_dat_i. WRITE -> NEXT.
    - err (also if ack and err arrive together): st=01 -> ABORT.
    - Counter reaches TIMEOUT_CYCLES with no response: drop cyc/stb, st=10 -> ABORT.
  - RPUSH: wait !full, push read data -> NEXT.
  - NEXT: remaining-1. Zero -> RESP (st=00). Otherwise addr+=4 -> WFETCH (WRITE) or BUS (READ).
  - ABORT:
    - WRITE: pop and discard all data words not yet fetched, preserving framing, -> RESP.
    - READ: -> RESP directly; no further data is pushed.
  - RESP: wait !full, push status -> IDLE.
- Minimum bus gap: cyc is low for at least one cycle between consecutive accesses.
- wb_adr_o and wb_we_o are held stable for the whole of BUS.
- The timeout counter clears on entering BUS.

Test Plan:
- WRITE N=1, header 32'h1000_0000, addr 32'h0000_0100, data 32'hDEAD_BEEF, ack 1 cycle after stb -> one bus write to 0x100 with DEADBEEF; response FIFO gets 32'hA100_0000.
- READ N=3 (header 32'h2020_0000), addr 0xFFFF_FFF8, slave returns 1,2,3 -> addresses FFFFFFF8, FFFFFFFC, 00000000; pushes 1,2,3 then 32'hA202_0000.
- WRITE N=4, err on the 2nd access -> exactly 2 bus cycles; the remaining 2 data words are drained; status 32'hA103_0001; the next queued command executes normally.
- READ N=1 with no ack, TIMEOUT_CYCLES=16 -> stb high for exactly 16 cycles, then drop; status 32'hA200_0002; no data word is pushed.
- Header 32'h7000_0000 -> no bus activity; status 32'hA700_0003; the next FIFO word is treated as a new header.
- fifoout_full_i held high during a READ, and a reset pulse asserted mid-BUS -> no push while full, data held stable; on reset, cyc/stb/busy go to 0 asynchronously and no status is pushed.

Source files
------------

// File: rtl/fifo2wb_master.sv
// fifo2wb_master
// Wishbone master driven by host command words arriving over a FIFO pair.
// It pops a command frame (header, address, optional write data) from the
// command FIFO. It runs one classic single-word Wishbone access per data word.
// It pushes read data, followed by one status word per command, into the
// response FIFO.
//
// Ports
//   clk, reset_n        : system clock, asynchronous active-low reset
//   fifoin_data_i       : command FIFO Q (valid the cycle after a pop)
//   fifoin_empty_i      : command FIFO empty
//   fifoin_rd_o         : command FIFO read enable (one pulse per word)
//   fifoout_data_o      : response word
//   fifoout_wr_o        : response FIFO write enable
//   fifoout_full_i      : response FIFO full
//   wb_*                : Wishbone classic master interface
//   busy_o              : high while a command is in progress
//
// Header word: [31:28] op (1 = WRITE, 2 = READ), [27:20] CNT, N = CNT+1.
// Status word: {4'hA, op, CNT, 14'b0, st}
//   st: 00 ok, 01 bus error, 10 timeout, 11 bad opcode.
module fifo2wb_master #(
  parameter int FT_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [FT_DATA_WIDTH-1:0]     fifoin_data_i,
  input  logic                         fifoin_empty_i,
  output logic                         fifoin_rd_o,
  output logic [FT_DATA_WIDTH-1:0]     fifoout_data_o,
  output logic                         fifoout_wr_o,
  input  logic                         fifoout_full_i,
  output logic [FT_DATA_WIDTH-1:0]     wb_adr_o,
  output logic [FT_DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [FT_DATA_WIDTH-1:0]     wb_dat_i,
  output logic                         wb_we_o,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic [FT_DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic [2:0]                   wb_cti_o,
  output logic [1:0]                   wb_bte_o,
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i,
  output logic                         busy_o
);

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HWAIT,
    S_ADDR,
    S_WFETCH,
    S_WDATA,
    S_BUS,
    S_RPUSH,
    S_NEXT,
    S_ABORT,
    S_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 op_q, op_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [8:0]                 rem_q, rem_d;
  logic [FT_DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [FT_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [FT_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                 st_q, st_d;
  logic [15:0]                tmo_q, tmo_d;
  logic                       cyc_q, cyc_d;
  logic                       we_q, we_d;

  function automatic logic [FT_DATA_WIDTH-1:0] status_word(
    input logic [3:0] op,
    input logic [7:0] cnt,
    input logic [1:0] st
  );
    logic [FT_DATA_WIDTH-1:0] w;
    w        = '0;
    w[31:28] = 4'hA;
    w[27:24] = op;
    w[23:16] = cnt;
    w[1:0]   = st;
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      st_q    <= '0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      st_q    <= st_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    st_d           = st_q;
    // Held at zero outside BUS, so every access starts its count from zero.
    tmo_d          = '0;
    fifoin_rd_o    = 1'b0;
    fifoout_wr_o   = 1'b0;
    fifoout_data_o = '0;

    case (state_q)
      S_IDLE: begin
        // reset_n gating keeps a held reset from silently consuming a word.
        if (!fifoin_empty_i && reset_n) begin
          fifoin_rd_o = 1'b1;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        op_d  = fifoin_data_i[31:28];
        cnt_d = fifoin_data_i[27:20];
        rem_d = {1'b0, fifoin_data_i[27:20]} + 9'd1;
        st_d  = 2'b00;
        if (fifoin_data_i[31:28] != OP_WRITE && fifoin_data_i[31:28] != OP_READ) begin
          st_d    = 2'b11;
          state_d = S_RESP;
        end else if (!fifoin_empty_i) begin
          fifoin_rd_o = 1'b1;
          state_d     = S_ADDR;
        end else begin
          // Header is latched now; wait here for the address word.
          state_d = S_HWAIT;
        end
      end
      S_HWAIT: begin
        if (!fifoin_empty_i) begin
          fifoin_rd_o = 1'b1;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        addr_d  = fifoin_data_i;
        state_d = (op_q == OP_WRITE) ? S_WFETCH : S_BUS;
      end
      S_WFETCH: begin
        if (!fifoin_empty_i) begin
          fifoin_rd_o = 1'b1;
          state_d     = S_WDATA;
        end
      end
      S_WDATA: begin
        wdata_d = fifoin_data_i;
        state_d = S_BUS;
      end
      S_BUS: begin
        // err wins over a simultaneous ack. rem drops by one so that, in
        // ABORT, it counts only the data words still sitting in the FIFO.
        if (wb_err_i) begin
          st_d    = 2'b01;
          rem_d   = rem_q - 9'd1;
          state_d = S_ABORT;
        end else if (wb_ack_i) begin
          if (op_q == OP_WRITE) begin
            state_d = S_NEXT;
          end else begin
            rdata_d = wb_dat_i;
            state_d = S_RPUSH;
          end
        end else if (tmo_q == TMO_LAST) begin
          st_d    = 2'b10;
          rem_d   = rem_q - 9'd1;
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RPUSH: begin
        fifoout_data_o = rdata_q;
        if (!fifoout_full_i) begin
          fifoout_wr_o = 1'b1;
          state_d      = S_NEXT;
        end
      end
      S_NEXT: begin
        rem_d = rem_q - 9'd1;
        if (rem_q == 9'd1) begin
          state_d = S_RESP;
        end else begin
          addr_d  = addr_q + FT_DATA_WIDTH'(4);
          state_d = (op_q == OP_WRITE) ? S_WFETCH : S_BUS;
        end
      end
      S_ABORT: begin
        // Drain unfetched write data so the next header is found in place.
        if (op_q == OP_WRITE && rem_q != 9'd0) begin
          if (!fifoin_empty_i) begin
            fifoin_rd_o = 1'b1;
            rem_d       = rem_q - 9'd1;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        fifoout_data_o = status_word(op_q, cnt_q, st_q);
        if (!fifoout_full_i) begin
          fifoout_wr_o = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // cyc/stb/we are registered from the next state. They rise on entry to
    // BUS and fall on the same edge that samples ack/err/timeout.
    cyc_d = (state_d == S_BUS);
    we_d  = (state_d == S_BUS) && (op_q == OP_WRITE);
  end

  assign wb_adr_o = addr_q;
  assign wb_dat_o = wdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = '1;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo2wb_master.sv
// tb_fifo2wb_master
// Directed bench for fifo2wb_master. It includes a command FIFO model
// (non-show-ahead), a response FIFO capture with a full control, and a
// Wishbone slave model with configurable error/no-ack behaviour.
module tb_fifo2wb_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fifoin_data_i = '0;
  logic        fifoin_empty_i;
  logic        fifoin_rd_o;
  logic [31:0] fifoout_data_o;
  logic        fifoout_wr_o;
  logic        fifoout_full_i = 1'b0;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        busy_o;

  fifo2wb_master #(.FT_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .fifoin_data_i(fifoin_data_i), .fifoin_empty_i(fifoin_empty_i), .fifoin_rd_o(fifoin_rd_o),
    .fifoout_data_o(fifoout_data_o), .fifoout_wr_o(fifoout_wr_o), .fifoout_full_i(fifoout_full_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Command FIFO model: the initial block writes, the clocked block reads.
  logic [31:0] cmd_mem [0:255];
  int          cmd_wp = 0;
  int          cmd_rp = 0;
  always_comb fifoin_empty_i = (cmd_rp == cmd_wp);

  // Response capture and protocol monitors.
  logic [31:0] rsp_mem [0:255];
  int          rsp_wp = 0;
  int          stb_cycles = 0;
  int          gap_viol = 0;
  int          adr_viol = 0;
  int          full_viol = 0;
  int          pop_viol = 0;
  logic        resp_seen = 1'b0;
  logic        cyc_prev = 1'b0;
  logic        we_prev = 1'b0;
  logic [31:0] adr_prev = '0;

  always @(posedge clk) begin
    if (fifoin_rd_o) begin
      fifoin_data_i <= cmd_mem[cmd_rp % 256];
      cmd_rp        <= cmd_rp + 1;
      if (fifoin_empty_i) pop_viol <= pop_viol + 1;
    end
    if (fifoout_wr_o) begin
      rsp_mem[rsp_wp % 256] <= fifoout_data_o;
      rsp_wp                <= rsp_wp + 1;
      if (fifoout_full_i) full_viol <= full_viol + 1;
    end
    if (wb_stb_o) stb_cycles <= stb_cycles + 1;
    if (wb_cyc_o && resp_seen) gap_viol <= gap_viol + 1;
    if (wb_cyc_o && cyc_prev && (wb_adr_o != adr_prev || wb_we_o != we_prev))
      adr_viol <= adr_viol + 1;
    resp_seen <= wb_ack_i | wb_err_i;
    cyc_prev  <= wb_cyc_o;
    adr_prev  <= wb_adr_o;
    we_prev   <= wb_we_o;
  end

  // Wishbone slave: responds ack_dly cycles after seeing stb (0 = next edge).
  int          ack_dly = 0;
  int          err_at = -1;
  bit          no_ack = 1'b0;
  logic [31:0] rd_tab  [0:63];
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic        log_we  [0:63];
  int          acc_total = 0;
  int          wait_cnt = 0;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
      if (!no_ack && wait_cnt >= ack_dly) begin
        log_adr[acc_total] <= wb_adr_o;
        log_dat[acc_total] <= wb_dat_o;
        log_we[acc_total]  <= wb_we_o;
        if (acc_total == err_at) begin
          wb_err_i <= 1'b1;
        end else begin
          wb_ack_i <= 1'b1;
          wb_dat_i <= rd_tab[acc_total];
        end
        acc_total <= acc_total + 1;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    cmd_mem[cmd_wp % 256] = w;
    cmd_wp++;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o || !fifoin_empty_i) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  int rb, ab, sb, n;

  initial begin
    for (int i = 0; i < 64; i++) rd_tab[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc",   32'(wb_cyc_o), 32'd0);
    chk("rst_stb",   32'(wb_stb_o), 32'd0);
    chk("rst_we",    32'(wb_we_o), 32'd0);
    chk("rst_adr",   wb_adr_o, 32'd0);
    chk("rst_dat",   wb_dat_o, 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_rd",    32'(fifoin_rd_o), 32'd0);
    chk("rst_wr",    32'(fifoout_wr_o), 32'd0);
    chk("rst_dout",  fifoout_data_o, 32'd0);
    chk("rst_sel",   {28'd0, wb_sel_o}, 32'hF);
    chk("rst_cti",   {29'd0, wb_cti_o}, 32'd0);
    chk("rst_bte",   {30'd0, wb_bte_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // WRITE N=1
    rb = rsp_wp; ab = acc_total;
    push(32'h1000_0000); push(32'h0000_0100); push(32'hDEAD_BEEF);
    wait_done("t1_done");
    chk("t1_nacc", 32'(acc_total - ab), 32'd1);
    chk("t1_adr",  log_adr[ab], 32'h0000_0100);
    chk("t1_we",   32'(log_we[ab]), 32'd1);
    chk("t1_dat",  log_dat[ab], 32'hDEAD_BEEF);
    chk("t1_nrsp", 32'(rsp_wp - rb), 32'd1);
    chk("t1_st",   rsp_mem[rb], 32'hA100_0000);

    // READ N=3 with address wrap
    rb = rsp_wp; ab = acc_total;
    rd_tab[ab] = 32'd1; rd_tab[ab+1] = 32'd2; rd_tab[ab+2] = 32'd3;
    push(32'h2020_0000); push(32'hFFFF_FFF8);
    wait_done("t2_done");
    chk("t2_nacc", 32'(acc_total - ab), 32'd3);
    chk("t2_adr0", log_adr[ab],   32'hFFFF_FFF8);
    chk("t2_adr1", log_adr[ab+1], 32'hFFFF_FFFC);
    chk("t2_adr2", log_adr[ab+2], 32'h0000_0000);
    chk("t2_we",   32'(log_we[ab+1]), 32'd0);
    chk("t2_nrsp", 32'(rsp_wp - rb), 32'd4);
    chk("t2_d0",   rsp_mem[rb],   32'd1);
    chk("t2_d1",   rsp_mem[rb+1], 32'd2);
    chk("t2_d2",   rsp_mem[rb+2], 32'd3);
    chk("t2_st",   rsp_mem[rb+3], 32'hA202_0000);

    // WRITE N=4, error on 2nd access, followed by a normal WRITE N=1
    rb = rsp_wp; ab = acc_total; err_at = ab + 1;
    push(32'h1030_0000); push(32'h0000_0200);
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    push(32'h1000_0000); push(32'h0000_0300); push(32'h55);
    wait_done("t3_done");
    err_at = -1;
    chk("t3_nacc", 32'(acc_total - ab), 32'd3);
    chk("t3_adr0", log_adr[ab],   32'h0000_0200);
    chk("t3_dat0", log_dat[ab],   32'h11);
    chk("t3_adr1", log_adr[ab+1], 32'h0000_0204);
    chk("t3_dat1", log_dat[ab+1], 32'h22);
    chk("t3_adr2", log_adr[ab+2], 32'h0000_0300);
    chk("t3_dat2", log_dat[ab+2], 32'h55);
    chk("t3_nrsp", 32'(rsp_wp - rb), 32'd2);
    chk("t3_st0",  rsp_mem[rb],   32'hA103_0001);
    chk("t3_st1",  rsp_mem[rb+1], 32'hA100_0000);

    // READ N=1, no response -> timeout after 16 strobe cycles
    rb = rsp_wp; ab = acc_total; sb = stb_cycles; no_ack = 1'b1;
    push(32'h2000_0000); push(32'h0000_0040);
    wait_done("t4_done");
    no_ack = 1'b0;
    chk("t4_stb",  32'(stb_cycles - sb), 32'd16);
    chk("t4_nacc", 32'(acc_total - ab), 32'd0);
    chk("t4_nrsp", 32'(rsp_wp - rb), 32'd1);
    chk("t4_st",   rsp_mem[rb], 32'hA200_0002);

    // Bad opcode, then a READ N=1 parsed as a fresh command
    rb = rsp_wp; ab = acc_total; sb = stb_cycles;
    rd_tab[ab] = 32'h0000_1234;
    push(32'h7000_0000); push(32'h2000_0000); push(32'h0000_0080);
    wait_done("t5_done");
    chk("t5_nacc", 32'(acc_total - ab), 32'd1);
    chk("t5_adr",  log_adr[ab], 32'h0000_0080);
    chk("t5_nrsp", 32'(rsp_wp - rb), 32'd3);
    chk("t5_st0",  rsp_mem[rb],   32'hA700_0003);
    chk("t5_d",    rsp_mem[rb+1], 32'h0000_1234);
    chk("t5_st1",  rsp_mem[rb+2], 32'hA200_0000);

    // Response FIFO full during READ
    rb = rsp_wp; ab = acc_total;
    rd_tab[ab] = 32'hCAFE_F00D;
    fifoout_full_i = 1'b1;
    push(32'h2000_0000); push(32'h0000_00C0);
    repeat (20) @(negedge clk);
    chk("t6_nacc",  32'(acc_total - ab), 32'd1);
    chk("t6_nrsp",  32'(rsp_wp - rb), 32'd0);
    chk("t6_busy",  32'(busy_o), 32'd1);
    chk("t6_wr",    32'(fifoout_wr_o), 32'd0);
    chk("t6_hold0", fifoout_data_o, 32'hCAFE_F00D);
    repeat (5) @(negedge clk);
    chk("t6_hold1", fifoout_data_o, 32'hCAFE_F00D);
    fifoout_full_i = 1'b0;
    wait_done("t6_done");
    chk("t6_nrsp2", 32'(rsp_wp - rb), 32'd2);
    chk("t6_d",     rsp_mem[rb],   32'hCAFE_F00D);
    chk("t6_st",    rsp_mem[rb+1], 32'hA200_0000);

    // Reset asserted mid-BUS
    rb = rsp_wp; no_ack = 1'b1;
    push(32'h2000_0000); push(32'h0000_00E0);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t7_cyc_up", 32'(wb_cyc_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_cyc",  32'(wb_cyc_o), 32'd0);
    chk("t7_stb",  32'(wb_stb_o), 32'd0);
    chk("t7_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("t7_wr",   32'(fifoout_wr_o), 32'd0);
    chk("t7_nrsp", 32'(rsp_wp - rb), 32'd0);
    reset_n = 1'b1;
    no_ack = 1'b0;
    @(negedge clk);

    // Recovery after reset: WRITE N=1
    rb = rsp_wp; ab = acc_total;
    push(32'h1000_0000); push(32'h0000_0010); push(32'h0000_0099);
    wait_done("t8_done");
    chk("t8_adr", log_adr[ab], 32'h0000_0010);
    chk("t8_dat", log_dat[ab], 32'h0000_0099);
    chk("t8_st",  rsp_mem[rb], 32'hA100_0000);

    // Protocol monitors over the whole run
    chk("mon_gap",  32'(gap_viol), 32'd0);
    chk("mon_adr",  32'(adr_viol), 32'd0);
    chk("mon_full", 32'(full_viol), 32'd0);
    chk("mon_pop",  32'(pop_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
